// File: rtl/signed_fixedpoint_align_pipe.sv
// rtl/signed_fixedpoint_align_pipe.sv - two-stage valid/ready pipe that aligns two signed fixed-point operands
`timescale 1ns/1ps
module signed_fixedpoint_align_pipe #(
    parameter int N       = 10,
    parameter int A_point = 4,
    parameter int B_point = 3,
    localparam int D      = (A_point >= B_point) ? (A_point - B_point) : (B_point - A_point),
    localparam int W      = N + D
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a_aligned,
    output logic [W-1:0] b_aligned,
    output logic [1:0]   occupancy
);

    logic         s1_valid_q, s1_valid_d;
    logic [N-1:0] s1_a_q, s1_a_d;
    logic [N-1:0] s1_b_q, s1_b_d;
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_a_q, s2_a_d;
    logic [W-1:0] s2_b_q, s2_b_d;
    logic [1:0]   occupancy_q, occupancy_d;

    logic                out_xfer;
    logic                in_xfer;
    logic                s2_load;
    logic                in_ready_c;
    logic signed [W-1:0] a_ext;
    logic signed [W-1:0] b_ext;

    always_comb begin
        out_xfer   = s2_valid_q & out_ready;
        s2_load    = s1_valid_q & (~s2_valid_q | out_xfer);
        in_ready_c = ~s1_valid_q | s2_load;
        in_xfer    = in_valid & in_ready_c;

        // W = N + D leaves exactly enough headroom for the shift, so it never wraps.
        a_ext = W'($signed(s1_a_q));
        b_ext = W'($signed(s1_b_q));
        if (A_point >= B_point) begin
            b_ext = b_ext <<< D;
        end else begin
            a_ext = a_ext <<< D;
        end

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_a_d     = s2_a_q;
        s2_b_d     = s2_b_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_a_d     = a_ext;
            s2_b_d     = b_ext;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end

        occupancy_d = {1'b0, s1_valid_d} + {1'b0, s2_valid_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            occupancy_q <= 2'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_a_q      <= s2_a_d;
            s2_b_q      <= s2_b_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = s2_valid_q;
    assign a_aligned = s2_a_q;
    assign b_aligned = s2_b_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_signed_fixedpoint_align_pipe.sv
// tb/tb_signed_fixedpoint_align_pipe.sv - randomized and directed bench for signed_fixedpoint_align_pipe
`timescale 1ns/1ps
module tb_signed_fixedpoint_align_pipe;

    localparam int NB = 10;
    localparam int AP = 4;
    localparam int BP = 3;
    localparam int FP = 4;
    localparam int WB = 11;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [WB-1:0] a_aligned;
    logic [WB-1:0] b_aligned;
    logic [1:0]    occupancy;

    logic          v_in_valid;
    logic [NB-1:0] v_a;
    logic [NB-1:0] v_b;
    logic          v_out_ready;
    logic          v1_in_ready, v1_out_valid;
    logic [10:0]   v1_a_aligned, v1_b_aligned;
    logic [1:0]    v1_occupancy;
    logic          v2_in_ready, v2_out_valid;
    logic [9:0]    v2_a_aligned, v2_b_aligned;
    logic [1:0]    v2_occupancy;

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];

    signed_fixedpoint_align_pipe #(.N(NB), .A_point(AP), .B_point(BP)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .a_aligned(a_aligned), .b_aligned(b_aligned), .occupancy(occupancy)
    );

    signed_fixedpoint_align_pipe #(.N(NB), .A_point(3), .B_point(4)) u_v1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v1_in_ready),
        .a(v_a), .b(v_b), .out_valid(v1_out_valid), .out_ready(v_out_ready),
        .a_aligned(v1_a_aligned), .b_aligned(v1_b_aligned), .occupancy(v1_occupancy)
    );

    signed_fixedpoint_align_pipe #(.N(NB), .A_point(4), .B_point(4)) u_v2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v2_in_ready),
        .a(v_a), .b(v_b), .out_valid(v2_out_valid), .out_ready(v_out_ready),
        .a_aligned(v2_a_aligned), .b_aligned(v2_b_aligned), .occupancy(v2_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value scaled to FP fraction bits: x * 2^(FP - point).
    function automatic int ref_align(input logic [NB-1:0] x, input int pt);
        return int'($signed(x)) * (1 << (FP - pt));
    endfunction

    task automatic step(input logic v, input logic [NB-1:0] av, input logic [NB-1:0] bv,
                        input logic ordy, output logic in_x, output logic out_x,
                        output int oa, output int ob);
        @(negedge clk);
        in_valid  = v;
        a         = av;
        b         = bv;
        out_ready = ordy;
        #1;
        in_x  = in_valid && in_ready;
        out_x = out_valid && out_ready;
        oa    = int'($signed(a_aligned));
        ob    = int'($signed(b_aligned));
        if (in_x) begin
            qa.push_back(ref_align(av, AP));
            qb.push_back(ref_align(bv, BP));
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || a_aligned !== '0 || b_aligned !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: out_valid=%b occ=%0d a=%0h b=%0h in_ready=%b, want 0 0 0 0 1",
                     out_valid, occupancy, a_aligned, b_aligned, in_ready);
        end
    endtask

    task automatic test_directed();
        int da[4] = '{83, -83, 0, 511};
        int db[4] = '{41, -42, -512, 511};
        int ea[4] = '{83, -83, 0, 511};
        int eb[4] = '{82, -84, -1024, 1022};
        logic ix, ox;
        int oa, ob;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'(da[i]), 10'(db[i]), 1'b1, ix, ox, oa, ob);
            checks++;
            if (ix !== 1'b1) begin errors++; $display("FAIL directed_accept[%0d]: got %b want 1", i, ix); end
            step(1'b0, '0, '0, 1'b1, ix, ox, oa, ob);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL directed_early[%0d]: out_valid=%b want 0", i, out_valid); end
            step(1'b0, '0, '0, 1'b1, ix, ox, oa, ob);
            checks++;
            if (ox !== 1'b1 || oa != ea[i] || ob != eb[i]) begin
                errors++;
                $display("FAIL directed[%0d]: valid=%b a=%0d b=%0d want 1 %0d %0d", i, ox, oa, ob, ea[i], eb[i]);
            end
            if (qa.size() > 0) begin void'(qa.pop_front()); void'(qb.pop_front()); end
        end
        step(1'b0, '0, '0, 1'b1, ix, ox, oa, ob);
    endtask

    task automatic test_backpressure();
        int sa[3] = '{80, 100, 80};
        int sb[3] = '{40, 40, 50};
        int ea[3] = '{80, 100, 80};
        int eb[3] = '{80, 80, 100};
        int sent = 0;
        int got = 0;
        logic ix, ox;
        int oa, ob;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            step(sent < 3, (sent < 3) ? 10'(sa[sent]) : '0, (sent < 3) ? 10'(sb[sent]) : '0,
                 cyc >= 4, ix, ox, oa, ob);
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_valid !== 1'b1 || oa != 80 || ob != 80) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: in_ready=%b occ=%0d valid=%b a=%0d b=%0d want 0 2 1 80 80",
                             cyc, in_ready, occupancy, out_valid, oa, ob);
                end
            end
            if (ix) sent++;
            if (ox) begin
                checks++;
                if (oa != ea[got] || ob != eb[got]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: a=%0d b=%0d want %0d %0d", got, oa, ob, ea[got], eb[got]);
                end
                got++;
                void'(qa.pop_front()); void'(qb.pop_front());
            end
        end
        checks++;
        if (got != 3) begin errors++; $display("FAIL bp_count: got %0d outputs want 3", got); end
    endtask

    task automatic test_full_rate();
        int got = 0;
        int first = -1;
        int last = -1;
        logic ix, ox;
        int oa, ob;
        int ea, eb;
        for (int cyc = 0; cyc < 14; cyc++) begin
            step(cyc < 8, 10'($urandom), 10'($urandom), 1'b1, ix, ox, oa, ob);
            if (cyc < 8) begin
                checks++;
                if (ix !== 1'b1) begin errors++; $display("FAIL full_rate_accept[%0d]: got %b want 1", cyc, ix); end
            end
            if (ox) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                checks++;
                if (oa != ea || ob != eb) begin
                    errors++;
                    $display("FAIL full_rate_data[%0d]: a=%0d b=%0d want %0d %0d", got, oa, ob, ea, eb);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
        end
        checks++;
        if (got != 8 || last - first != 7) begin
            errors++;
            $display("FAIL full_rate_span: outputs=%0d span=%0d want 8 7", got, last - first);
        end
    endtask

    task automatic test_random_traffic();
        int got = 0;
        logic ix, ox;
        int oa, ob;
        int ea, eb;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step(cyc < 300 && $urandom_range(0, 3) != 0, 10'($urandom), 10'($urandom),
                 cyc >= 300 || $urandom_range(0, 2) != 0, ix, ox, oa, ob);
            if (ox) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra: output a=%0d b=%0d with empty model", oa, ob);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    if (oa != ea || ob != eb) begin
                        errors++;
                        $display("FAIL random_data[%0d]: a=%0d b=%0d want %0d %0d", got, oa, ob, ea, eb);
                    end
                end
                got++;
            end
        end
        checks++;
        if (qa.size() != 0) begin errors++; $display("FAIL random_drain: %0d pairs left want 0", qa.size()); end
        qa.delete();
        qb.delete();
    endtask

    task automatic test_reset_mid();
        logic ix, ox;
        int oa, ob;
        int ea, eb;
        int got = 0;
        logic [NB-1:0] na, nb;
        step(1'b1, 10'd7, 10'd9, 1'b0, ix, ox, oa, ob);
        step(1'b1, 10'd11, 10'd13, 1'b0, ix, ox, oa, ob);
        step(1'b0, '0, '0, 1'b0, ix, ox, oa, ob);
        checks++;
        if (occupancy !== 2'd2) begin errors++; $display("FAIL reset_mid_fill: occ=%0d want 2", occupancy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || a_aligned !== '0 || b_aligned !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b occ=%0d a=%0h b=%0h want 0 0 0 0", out_valid, occupancy, a_aligned, b_aligned);
        end
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        na = 10'($urandom);
        nb = 10'($urandom);
        step(1'b1, na, nb, 1'b1, ix, ox, oa, ob);
        for (int cyc = 0; cyc < 6 && got == 0; cyc++) begin
            step(1'b0, '0, '0, 1'b1, ix, ox, oa, ob);
            if (ox) begin
                ea = ref_align(na, AP);
                eb = ref_align(nb, BP);
                checks++;
                if (oa != ea || ob != eb) begin
                    errors++;
                    $display("FAIL reset_mid_first: a=%0d b=%0d want %0d %0d", oa, ob, ea, eb);
                end
                got++;
            end
        end
        checks++;
        if (got != 1) begin errors++; $display("FAIL reset_mid_timeout: outputs=%0d want 1", got); end
        qa.delete();
        qb.delete();
    endtask

    task automatic test_variants();
        @(negedge clk);
        v_in_valid  = 1'b1;
        v_a         = 10'd41;
        v_b         = 10'd83;
        v_out_ready = 1'b1;
        @(negedge clk);
        v_in_valid = 1'b0;
        checks++;
        if (v1_out_valid !== 1'b0 || v2_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL variant_early: v1=%b v2=%b want 0 0", v1_out_valid, v2_out_valid);
        end
        @(negedge clk);
        checks++;
        if (v1_out_valid !== 1'b1 || $signed(v1_a_aligned) != 82 || $signed(v1_b_aligned) != 83) begin
            errors++;
            $display("FAIL variant_3_4: valid=%b a=%0d b=%0d want 1 82 83",
                     v1_out_valid, $signed(v1_a_aligned), $signed(v1_b_aligned));
        end
        checks++;
        if (v2_out_valid !== 1'b1 || $signed(v2_a_aligned) != 41 || $signed(v2_b_aligned) != 83) begin
            errors++;
            $display("FAIL variant_4_4: valid=%b a=%0d b=%0d want 1 41 83",
                     v2_out_valid, $signed(v2_a_aligned), $signed(v2_b_aligned));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        out_ready   = 1'b0;
        v_in_valid  = 1'b0;
        v_a         = '0;
        v_b         = '0;
        v_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_directed();
        test_backpressure();
        test_full_rate();
        test_random_traffic();
        test_reset_mid();
        test_variants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
